rf_wb_arbiter: RTL and testbench

Write-port arbiter and sequencer for the processor's 32x32 register file. It shares the single register-file write port between NREQ writeback requesters, such as ALU, load and multiply/divide, using round-robin arbitration and a valid/ready handshake. It registers the winning write onto the register-file write port. An optional forwarding path returns the staged write to the two read ports, so readers see it in the same cycle. The block sits between the execute/memory writeback sources and the register file.

---
 rtl/rf_wb_arbiter.sv | 116 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the 32x32 register-file write port.
// Define RFWB_FWD_EN to add same-cycle forwarding of the staged write.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_idx,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 stall,
  output logic                 wr_en,
  output logic [4:0]           wr_idx,
  output logic [XLEN-1:0]      wr_data,
  output logic                 busy
`ifdef RFWB_FWD_EN
  ,
  input  logic [4:0]           rda_idx,
  input  logic [4:0]           rdb_idx,
  input  logic [XLEN-1:0]      rda_in,
  input  logic [XLEN-1:0]      rdb_in,
  output logic [XLEN-1:0]      rda_fwd,
  output logic [XLEN-1:0]      rdb_fwd
`endif
);

  localparam int PW  = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int PW1 = PW + 1;

  logic [PW-1:0]   r_rr_ptr;
  logic            r_wr_en;
  logic [4:0]      r_wr_idx;
  logic [XLEN-1:0] r_wr_data;

  logic [PW1-1:0]  w_sum;
  logic            w_hit;
  logic            w_found;
  logic [PW-1:0]   w_gidx;
  logic [PW-1:0]   w_nxt;
  logic [NREQ-1:0] w_gnt;
  logic [4:0]      w_idx;
  logic [XLEN-1:0] w_data;

  // Scan from rr_ptr upward, wrapping modulo NREQ; first valid wins.
  always_comb begin
    w_sum   = '0;
    w_hit   = 1'b0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + PW1'(k);
      if (w_sum >= PW1'(NREQ))
        w_sum = w_sum - PW1'(NREQ);
      w_hit = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (w_sum == PW1'(i))
          w_hit = req_valid[i];
      end
      if (!stall && !w_found && w_hit) begin
        w_found = 1'b1;
        w_gidx  = w_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_found)
      w_gnt = NREQ'(1) << w_gidx;
  end

  always_comb begin
    w_idx  = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_idx  = req_idx[5*i +: 5];
        w_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  assign w_nxt = (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
    end else if (w_found) begin
      r_rr_ptr  <= w_nxt;
      r_wr_en   <= (w_idx != 5'd0);
      r_wr_idx  <= w_idx;
      r_wr_data <= w_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign req_ready = w_gnt;
  assign wr_en     = r_wr_en;
  assign wr_idx    = r_wr_idx;
  assign wr_data   = r_wr_data;
  assign busy      = r_wr_en | (|req_valid);

`ifdef RFWB_FWD_EN
  assign rda_fwd = (r_wr_en && r_wr_idx == rda_idx && rda_idx != 5'd0)
                 ? r_wr_data : rda_in;
  assign rdb_fwd = (r_wr_en && r_wr_idx == rdb_idx && rdb_idx != 5'd0)
                 ? r_wr_data : rdb_in;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: queued expectations checked by a negedge monitor.
// Builds with or without RFWB_FWD_EN.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*5-1:0]    req_idx = '0;
  logic [NREQ*XLEN-1:0] req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 stall = 1'b0;
  logic                 wr_en;
  logic [4:0]           wr_idx;
  logic [XLEN-1:0]      wr_data;
  logic                 busy;
`ifdef RFWB_FWD_EN
  logic [4:0]           rda_idx = '0;
  logic [4:0]           rdb_idx = '0;
  logic [XLEN-1:0]      rda_in = '0;
  logic [XLEN-1:0]      rdb_in = '0;
  logic [XLEN-1:0]      rda_fwd;
  logic [XLEN-1:0]      rdb_fwd;
`endif

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_idx(req_idx),
    .req_data(req_data), .req_ready(req_ready),
    .stall(stall), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .busy(busy)
`ifdef RFWB_FWD_EN
    , .rda_idx(rda_idx), .rdb_idx(rdb_idx),
    .rda_in(rda_in), .rdb_in(rdb_in),
    .rda_fwd(rda_fwd), .rdb_fwd(rdb_fwd)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        en;
    bit [4:0]  idx;
    bit [31:0] data;
  } wr_t;

  int n_chk = 0;
  int n_fail = 0;

  bit        pend[NREQ];
  bit [4:0]  pidx[NREQ];
  bit [31:0] pdat[NREQ];
  bit        m_stall;
  int        mptr;
  bit [4:0]  last_idx;
  bit [31:0] last_dat;

  wr_t            q_wr[$];
  bit [NREQ-1:0]  q_rdy[$];
  bit             mon_en = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: scan requesters from the model pointer with modulo wrap.
  task automatic step();
    int g;
    wr_t w;
    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend[i];
      req_idx[5*i +: 5]     = pidx[i];
      req_data[32*i +: 32]  = pdat[i];
    end
    stall = m_stall;
    if (!m_stall)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && pend[(mptr + k) % NREQ])
          g = (mptr + k) % NREQ;
    if (g >= 0) begin
      q_rdy.push_back(NREQ'(1) << g);
      w.en = (pidx[g] != 0);
      last_idx = pidx[g];
      last_dat = pdat[g];
      mptr = (g + 1) % NREQ;
      pend[g] = 1'b0;
    end else begin
      q_rdy.push_back('0);
      w.en = 1'b0;
    end
    w.idx  = last_idx;
    w.data = last_dat;
    q_wr.push_back(w);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    step();
  endtask

  task automatic arm(int i, bit [4:0] ix, bit [31:0] d);
    if (!pend[i]) begin
      pend[i] = 1'b1;
      pidx[i] = ix;
      pdat[i] = d;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
  endtask

  task automatic model_reset();
    wr_t w;
    q_wr.delete();
    q_rdy.delete();
    mptr = 0;
    last_idx = '0;
    last_dat = '0;
    w.en = 1'b0;
    w.idx = '0;
    w.data = '0;
    q_wr.push_back(w);
  endtask

  task automatic do_reset(bit mid);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    if (mid) chk("mid_rst_pre_wr_en", wr_en, 1);
    rst = 1'b1;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    model_reset();
    step();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q_wr.size() == 0 || q_rdy.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got %0d expected >0", q_wr.size());
      end else begin
        wr_t e;
        bit [NREQ-1:0] r;
        e = q_wr.pop_front();
        r = q_rdy.pop_front();
        chk("sb_ready", req_ready, r);
        chk("sb_wr_en", wr_en, e.en);
        chk("sb_wr_idx", wr_idx, e.idx);
        chk("sb_wr_data", wr_data, e.data);
        chk("sb_busy", busy, e.en | (|req_valid));
      end
    end
  end

  localparam int GSEQ[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    m_stall = 1'b0;
    clr();
    #3;
    chk("init_wr_en", wr_en, 0);
    chk("init_busy", busy, 0);
    chk("init_ready", req_ready, 0);

    // single request from requester 1
    clr();
    arm(1, 5'd5, 32'hDEADBEEF);
    do_reset(1'b0);
    #1;
    chk("t1_ready", req_ready, 3'b010);
    mon_en = 1'b1;
    arm(0, 5'd1, 32'h11);
    arm(1, 5'd2, 32'h22);
    arm(2, 5'd3, 32'h33);
    cyc();
    #1;
    chk("t1_wr_en", wr_en, 1);
    chk("t1_wr_idx", wr_idx, 5);
    chk("t1_wr_data", wr_data, 32'hDEADBEEF);
    chk("t1_ptr2_ready", req_ready, 3'b100);

    // all requesters continuously valid from reset
    clr();
    for (int i = 0; i < NREQ; i++) arm(i, 5'(i + 1), $urandom);
    do_reset(1'b0);
    #1;
    chk("t2_gnt0", req_ready, 3'b001);
    mon_en = 1'b1;
    for (int k = 1; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) arm(i, 5'(i + 1), $urandom);
      cyc();
      #1;
      chk("t2_gnt", req_ready, NREQ'(1) << GSEQ[k]);
      chk("t2_wr_en", wr_en, 1);
    end

    // write to x0 is acknowledged but not written
    clr();
    arm(0, 5'd0, 32'h1234);
    do_reset(1'b0);
    #1;
    chk("t3_ready", req_ready, 3'b001);
    mon_en = 1'b1;
    cyc();
    #1;
    chk("t3_wr_en", wr_en, 0);

    // stall for three cycles
    clr();
    for (int i = 0; i < NREQ; i++) arm(i, 5'(i + 1), $urandom);
    do_reset(1'b0);
    mon_en = 1'b1;
    arm(0, 5'd1, 32'h55);
    m_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk("t4_stall_ready", req_ready, 0);
      chk("t4_stall_wr_en", wr_en, (k == 0) ? 1 : 0);
    end
    m_stall = 1'b0;
    cyc();
    #1;
    chk("t4_resume", req_ready, 3'b010);

    // asynchronous reset between edges with a staged write
    for (int i = 0; i < NREQ; i++) arm(i, 5'(i + 1), $urandom);
    cyc();
    for (int i = 0; i < NREQ; i++) arm(i, 5'(i + 1), $urandom);
    do_reset(1'b1);
    #1;
    chk("t5_first_gnt", req_ready, 3'b001);
    mon_en = 1'b1;

`ifdef RFWB_FWD_EN
    clr();
    arm(0, 5'd7, 32'hA5A5A5A5);
    do_reset(1'b0);
    mon_en = 1'b1;
    cyc();
    rda_idx = 5'd7;
    rdb_idx = 5'd8;
    rda_in  = 32'h1111;
    rdb_in  = 32'h2222;
    #1;
    chk("fwd_a", rda_fwd, 32'hA5A5A5A5);
    chk("fwd_b", rdb_fwd, 32'h2222);
    clr();
    arm(0, 5'd0, 32'h77);
    do_reset(1'b0);
    mon_en = 1'b1;
    cyc();
    rda_idx = 5'd0;
    #1;
    chk("fwd_x0", rda_fwd, 32'h1111);
`endif

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 2) != 0)
          arm(i, 5'($urandom_range(0, 31)), $urandom);
      m_stall = ($urandom_range(0, 9) == 0);
      cyc();
    end

    #5;
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
